// File: rtl/jtag_pkg.sv
// jtag_pkg
// Shared definitions for the TAP controller: the 16 TAP state encodings,
// the instruction opcodes, the IR capture pattern and the internal DR
// select type.
// No ports; imported by jtag_tap_fsm, jtag_tap and the testbench.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_TLR     = 4'h0,
    TAP_RTI     = 4'h1,
    TAP_SELDR   = 4'h2,
    TAP_CAPDR   = 4'h3,
    TAP_SHDR    = 4'h4,
    TAP_EX1DR   = 4'h5,
    TAP_PAUSEDR = 4'h6,
    TAP_EX2DR   = 4'h7,
    TAP_UPDDR   = 4'h8,
    TAP_SELIR   = 4'h9,
    TAP_CAPIR   = 4'hA,
    TAP_SHIR    = 4'hB,
    TAP_EX1IR   = 4'hC,
    TAP_PAUSEIR = 4'hD,
    TAP_EX2IR   = 4'hE,
    TAP_UPDIR   = 4'hF
  } tap_state_e;

  // Opcodes are given as integers and sized to IR_BITS at the point of use.
  // BYPASS is all-ones, expressed as -1 so the sized cast fills every bit.
  localparam int OP_EXTEST   = 0;
  localparam int OP_IDCODE   = 1;
  localparam int OP_SCAN_N   = 2;
  localparam int OP_USERCODE = 3;
  localparam int OP_BYPASS   = -1;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  typedef enum logic [1:0] {
    SEL_BYPASS   = 2'd0,
    SEL_IDCODE   = 2'd1,
    SEL_USERCODE = 2'd2,
    SEL_GPIO     = 2'd3
  } dr_sel_e;

endpackage

// File: rtl/jtag_tap_if.sv
// jtag_tap_if
// Groups the TAP pin signals (tms/tdi/tdo/tdo_ena) and the signals shared
// with the downstream GPIO scan-chain block (gpios_tdo, DR strobes,
// instruction selects, debug state).
// Modports: master = JTAG host / GPIO side, slave = the TAP controller.
interface jtag_tap_if;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_ena;
  logic       gpios_tdo;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_dr;
  logic       scan_n_ir;
  logic       extest_ir;
  logic [3:0] tap_state;

  modport master (
    output tms, tdi, gpios_tdo,
    input  tdo, tdo_ena, capture_dr, shift_dr, update_dr,
           scan_n_ir, extest_ir, tap_state
  );

  modport slave (
    input  tms, tdi, gpios_tdo,
    output tdo, tdo_ena, capture_dr, shift_dr, update_dr,
           scan_n_ir, extest_ir, tap_state
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm
// 16-state TAP controller: state register, TMS next-state logic and
// zero-latency state decodes.
// Ports: tck, reset (sync, active-high), tms in; state plus one-hot
// decodes (in_tlr, capture/shift/update for DR and IR) out.
//
// state   | meaning
// --------+----------------------------------------------
// TLR     | test-logic-reset, IR forced to IDCODE
// RTI     | run-test/idle
// SELDR   | select DR scan
// CAPDR   | parallel load of the selected DR
// SHDR    | shift selected DR, tdo enabled
// EX1DR   | exit1 DR, registers held
// PAUSEDR | pause DR, registers held
// EX2DR   | exit2 DR, registers held
// UPDDR   | update DR strobe
// SELIR   | select IR scan
// CAPIR   | load IR shifter with capture pattern
// SHIR    | shift IR shifter, tdo enabled
// EX1IR   | exit1 IR, registers held
// PAUSEIR | pause IR, registers held
// EX2IR   | exit2 IR, registers held
// UPDIR   | transfer IR shifter into IR
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       reset,
  input  logic       tms,
  output tap_state_e state,
  output logic       in_tlr,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir
);

  tap_state_e state_q, state_d;

  always_ff @(posedge tck) begin
    if (reset) state_q <= TAP_TLR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TAP_TLR:     state_d = tms ? TAP_TLR     : TAP_RTI;
      TAP_RTI:     state_d = tms ? TAP_SELDR   : TAP_RTI;
      TAP_SELDR:   state_d = tms ? TAP_SELIR   : TAP_CAPDR;
      TAP_CAPDR:   state_d = tms ? TAP_EX1DR   : TAP_SHDR;
      TAP_SHDR:    state_d = tms ? TAP_EX1DR   : TAP_SHDR;
      TAP_EX1DR:   state_d = tms ? TAP_UPDDR   : TAP_PAUSEDR;
      TAP_PAUSEDR: state_d = tms ? TAP_EX2DR   : TAP_PAUSEDR;
      TAP_EX2DR:   state_d = tms ? TAP_UPDDR   : TAP_SHDR;
      TAP_UPDDR:   state_d = tms ? TAP_SELDR   : TAP_RTI;
      TAP_SELIR:   state_d = tms ? TAP_TLR     : TAP_CAPIR;
      TAP_CAPIR:   state_d = tms ? TAP_EX1IR   : TAP_SHIR;
      TAP_SHIR:    state_d = tms ? TAP_EX1IR   : TAP_SHIR;
      TAP_EX1IR:   state_d = tms ? TAP_UPDIR   : TAP_PAUSEIR;
      TAP_PAUSEIR: state_d = tms ? TAP_EX2IR   : TAP_PAUSEIR;
      TAP_EX2IR:   state_d = tms ? TAP_UPDIR   : TAP_SHIR;
      TAP_UPDIR:   state_d = tms ? TAP_SELDR   : TAP_RTI;
      default:     state_d = TAP_TLR;
    endcase
  end

  always_comb begin
    state      = state_q;
    in_tlr     = (state_q == TAP_TLR);
    capture_dr = (state_q == TAP_CAPDR);
    shift_dr   = (state_q == TAP_SHDR);
    update_dr  = (state_q == TAP_UPDDR);
    capture_ir = (state_q == TAP_CAPIR);
    shift_ir   = (state_q == TAP_SHIR);
    update_ir  = (state_q == TAP_UPDIR);
  end

endmodule

// File: rtl/jtag_tap.sv
// jtag_tap
// TAP controller top: instruction register, IDCODE/BYPASS (and optional
// USERCODE) data registers, instruction decode and the tdo mux.
// Ports: tck, reset (sync, active-high), bus (jtag_tap_if.slave) carrying
// tms/tdi/tdo/tdo_ena, gpios_tdo, DR strobes, scan_n/extest selects and
// the debug tap_state.
// Build option: define JTAG_TAP_USERCODE_EN to add the 32-bit USERCODE DR
// on opcode 3; without it opcode 3 falls through to BYPASS.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int          IR_BITS        = 4,
  parameter logic [31:0] IDCODE_VALUE   = 32'h0000_0001,
  parameter logic [31:0] USERCODE_VALUE = 32'h0000_0000
) (
  input  logic       tck,
  input  logic       reset,
  jtag_tap_if.slave  bus
);

  localparam logic [IR_BITS-1:0] IR_EXTEST   = IR_BITS'(OP_EXTEST);
  localparam logic [IR_BITS-1:0] IR_IDCODE   = IR_BITS'(OP_IDCODE);
  localparam logic [IR_BITS-1:0] IR_SCAN_N   = IR_BITS'(OP_SCAN_N);

  tap_state_e state;
  logic in_tlr, capture_dr, shift_dr, update_dr;
  logic capture_ir, shift_ir, update_ir;

  jtag_tap_fsm u_fsm (
    .tck        (tck),
    .reset      (reset),
    .tms        (bus.tms),
    .state      (state),
    .in_tlr     (in_tlr),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir)
  );

  logic [IR_BITS-1:0] ir_q, ir_d;
  logic [IR_BITS-1:0] ir_shift_q, ir_shift_d;
  logic [31:0]        idcode_dr_q, idcode_dr_d;
  logic               bypass_dr_q, bypass_dr_d;
  dr_sel_e            dr_sel;
  logic               tdo_mux;

  // Anything not explicitly recognised selects the 1-bit bypass register.
  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir_q == IR_EXTEST || ir_q == IR_SCAN_N) dr_sel = SEL_GPIO;
    else if (ir_q == IR_IDCODE)                 dr_sel = SEL_IDCODE;
`ifdef JTAG_TAP_USERCODE_EN
    else if (ir_q == IR_BITS'(OP_USERCODE))     dr_sel = SEL_USERCODE;
`endif
  end

  always_comb begin
    ir_shift_d = ir_shift_q;
    if (capture_ir)    ir_shift_d = IR_BITS'(IR_CAPTURE);
    else if (shift_ir) ir_shift_d = {bus.tdi, ir_shift_q[IR_BITS-1:1]};

    ir_d = ir_q;
    if (in_tlr)         ir_d = IR_IDCODE;
    else if (update_ir) ir_d = ir_shift_q;

    idcode_dr_d = idcode_dr_q;
    bypass_dr_d = bypass_dr_q;
    if (dr_sel == SEL_IDCODE) begin
      if (capture_dr)    idcode_dr_d = IDCODE_VALUE;
      else if (shift_dr) idcode_dr_d = {bus.tdi, idcode_dr_q[31:1]};
    end
    if (dr_sel == SEL_BYPASS) begin
      if (capture_dr)    bypass_dr_d = 1'b0;
      else if (shift_dr) bypass_dr_d = bus.tdi;
    end
  end

  always_ff @(posedge tck) begin
    if (reset) begin
      ir_q        <= IR_IDCODE;
      ir_shift_q  <= '0;
      idcode_dr_q <= '0;
      bypass_dr_q <= 1'b0;
    end else begin
      ir_q        <= ir_d;
      ir_shift_q  <= ir_shift_d;
      idcode_dr_q <= idcode_dr_d;
      bypass_dr_q <= bypass_dr_d;
    end
  end

`ifdef JTAG_TAP_USERCODE_EN
  logic [31:0] usercode_dr_q, usercode_dr_d;

  always_comb begin
    usercode_dr_d = usercode_dr_q;
    if (dr_sel == SEL_USERCODE) begin
      if (capture_dr)    usercode_dr_d = USERCODE_VALUE;
      else if (shift_dr) usercode_dr_d = {bus.tdi, usercode_dr_q[31:1]};
    end
  end

  always_ff @(posedge tck) begin
    if (reset) usercode_dr_q <= '0;
    else       usercode_dr_q <= usercode_dr_d;
  end
`else
  // USERCODE_VALUE has no register to load in this build.
  logic unused_usercode_value;
  assign unused_usercode_value = ^USERCODE_VALUE;
`endif

  always_comb begin
    tdo_mux = 1'b0;
    if (shift_ir) begin
      tdo_mux = ir_shift_q[0];
    end else if (shift_dr) begin
      case (dr_sel)
        SEL_GPIO:     tdo_mux = bus.gpios_tdo;
        SEL_IDCODE:   tdo_mux = idcode_dr_q[0];
`ifdef JTAG_TAP_USERCODE_EN
        SEL_USERCODE: tdo_mux = usercode_dr_q[0];
`endif
        default:      tdo_mux = bypass_dr_q;
      endcase
    end
  end

  assign bus.tdo        = tdo_mux;
  assign bus.tdo_ena    = shift_ir | shift_dr;
  assign bus.capture_dr = capture_dr;
  assign bus.shift_dr   = shift_dr;
  assign bus.update_dr  = update_dr;
  assign bus.scan_n_ir  = (ir_q == IR_SCAN_N);
  assign bus.extest_ir  = (ir_q == IR_EXTEST);
  assign bus.tap_state  = state;

endmodule

// File: tb/tb_jtag_tap.sv
// tb_jtag_tap
// Directed scenarios plus a randomized TMS/TDI/reset run, compared every
// cycle against a behavioural model kept in the bench.
module tb_jtag_tap;
  import jtag_pkg::*;

  localparam int          IRB = 4;
  localparam logic [31:0] IDV = 32'h1234_5679;
  localparam logic [31:0] UCV = 32'hCAFE_0003;

  logic tck = 1'b0;
  logic reset = 1'b1;

  jtag_tap_if bus ();

  jtag_tap #(
    .IR_BITS        (IRB),
    .IDCODE_VALUE   (IDV),
    .USERCODE_VALUE (UCV)
  ) dut (
    .tck   (tck),
    .reset (reset),
    .bus   (bus)
  );

  always #5 tck = ~tck;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: TMS graph as a lookup table, registers as plain integers.
  tap_state_e  nxt [2][16];
  tap_state_e  m_st;
  int unsigned m_ir, m_irsh;
  logic [31:0] m_idc;
  logic        m_byp;
`ifdef JTAG_TAP_USERCODE_EN
  logic [31:0] m_uc;
`endif
  logic        g_cur;

  task automatic edge_of(input tap_state_e s, input tap_state_e on0, input tap_state_e on1);
    nxt[0][s] = on0;
    nxt[1][s] = on1;
  endtask

  task automatic init_table();
    edge_of(TAP_TLR,     TAP_RTI,     TAP_TLR);
    edge_of(TAP_RTI,     TAP_RTI,     TAP_SELDR);
    edge_of(TAP_SELDR,   TAP_CAPDR,   TAP_SELIR);
    edge_of(TAP_CAPDR,   TAP_SHDR,    TAP_EX1DR);
    edge_of(TAP_SHDR,    TAP_SHDR,    TAP_EX1DR);
    edge_of(TAP_EX1DR,   TAP_PAUSEDR, TAP_UPDDR);
    edge_of(TAP_PAUSEDR, TAP_PAUSEDR, TAP_EX2DR);
    edge_of(TAP_EX2DR,   TAP_SHDR,    TAP_UPDDR);
    edge_of(TAP_UPDDR,   TAP_RTI,     TAP_SELDR);
    edge_of(TAP_SELIR,   TAP_CAPIR,   TAP_TLR);
    edge_of(TAP_CAPIR,   TAP_SHIR,    TAP_EX1IR);
    edge_of(TAP_SHIR,    TAP_SHIR,    TAP_EX1IR);
    edge_of(TAP_EX1IR,   TAP_PAUSEIR, TAP_UPDIR);
    edge_of(TAP_PAUSEIR, TAP_PAUSEIR, TAP_EX2IR);
    edge_of(TAP_EX2IR,   TAP_SHIR,    TAP_UPDIR);
    edge_of(TAP_UPDIR,   TAP_RTI,     TAP_SELDR);
  endtask

  // 0 bypass, 1 idcode, 2 usercode, 3 gpio chain
  function automatic int dr_kind(input int unsigned ir);
    if (ir == 0 || ir == 2) return 3;
    if (ir == 1) return 1;
`ifdef JTAG_TAP_USERCODE_EN
    if (ir == 3) return 2;
`endif
    return 0;
  endfunction

  task automatic model_step(input logic tms_v, input logic tdi_v, input logic rst_v);
    if (rst_v) begin
      m_st = TAP_TLR; m_ir = 1; m_irsh = 0; m_idc = 0; m_byp = 0;
`ifdef JTAG_TAP_USERCODE_EN
      m_uc = 0;
`endif
      return;
    end
    if (m_st == TAP_TLR)   m_ir = 1;
    if (m_st == TAP_CAPIR) m_irsh = 1;
    if (m_st == TAP_SHIR)  m_irsh = (m_irsh >> 1) + (int'(tdi_v) << (IRB - 1));
    if (m_st == TAP_UPDIR) m_ir = m_irsh;
    if (m_st == TAP_CAPDR) begin
      case (dr_kind(m_ir))
        0: m_byp = 1'b0;
        1: m_idc = IDV;
`ifdef JTAG_TAP_USERCODE_EN
        2: m_uc = UCV;
`endif
        default: ;
      endcase
    end
    if (m_st == TAP_SHDR) begin
      case (dr_kind(m_ir))
        0: m_byp = tdi_v;
        1: m_idc = (m_idc >> 1) + (32'(tdi_v) << 31);
`ifdef JTAG_TAP_USERCODE_EN
        2: m_uc = (m_uc >> 1) + (32'(tdi_v) << 31);
`endif
        default: ;
      endcase
    end
    m_st = nxt[tms_v][m_st];
  endtask

  function automatic logic exp_tdo();
    if (m_st == TAP_SHIR) return m_irsh[0];
    if (m_st != TAP_SHDR) return 1'b0;
    case (dr_kind(m_ir))
      1: return m_idc[0];
`ifdef JTAG_TAP_USERCODE_EN
      2: return m_uc[0];
`endif
      3: return g_cur;
      default: return m_byp;
    endcase
  endfunction

  task automatic check_outputs(input string w);
    check({w, ":tap_state"},  32'(bus.tap_state),  32'(m_st));
    check({w, ":tdo_ena"},    32'(bus.tdo_ena),    32'(m_st == TAP_SHIR || m_st == TAP_SHDR));
    check({w, ":capture_dr"}, 32'(bus.capture_dr), 32'(m_st == TAP_CAPDR));
    check({w, ":shift_dr"},   32'(bus.shift_dr),   32'(m_st == TAP_SHDR));
    check({w, ":update_dr"},  32'(bus.update_dr),  32'(m_st == TAP_UPDDR));
    check({w, ":scan_n_ir"},  32'(bus.scan_n_ir),  32'(m_ir == 2));
    check({w, ":extest_ir"},  32'(bus.extest_ir),  32'(m_ir == 0));
    check({w, ":tdo"},        32'(bus.tdo),        32'(exp_tdo()));
  endtask

  logic tdo_pre;
  int   cap_cnt, upd_cnt;

  task automatic tick(input logic tms_v, input logic tdi_v = 1'b0,
                      input logic g_v = 1'b0, input logic rst_v = 1'b0);
    @(negedge tck);
    bus.tms = tms_v; bus.tdi = tdi_v; bus.gpios_tdo = g_v; reset = rst_v;
    g_cur = g_v;
    #1;
    check_outputs("pre");
    tdo_pre = bus.tdo;
    @(posedge tck);
    model_step(tms_v, tdi_v, rst_v);
    #1;
    check_outputs("post");
    if (bus.capture_dr) cap_cnt++;
    if (bus.update_dr)  upd_cnt++;
  endtask

  // From RTI: shift v into IR, return the bits seen on tdo, end in RTI.
  task automatic load_ir(input logic [IRB-1:0] v, output logic [IRB-1:0] seen);
    tick(1); tick(1); tick(0); tick(0);
    for (int i = 0; i < IRB; i++) begin
      tick(i == IRB - 1, v[i]);
      seen[i] = tdo_pre;
    end
    tick(1); tick(0);
  endtask

  // From RTI: shift n bits through the selected DR, end in RTI.
  task automatic shift_dr(input int n, input logic [63:0] din, input logic [63:0] g,
                          output logic [63:0] dout);
    dout = '0;
    tick(1); tick(0); tick(0);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i], g[i]);
      dout[i] = tdo_pre;
    end
    tick(1); tick(0);
  endtask

  logic [IRB-1:0] seen;
  logic [63:0]    dout;
  logic [63:0]    rnd;
  int             steps;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    init_table();
    bus.tms = 1'b1; bus.tdi = 1'b0; bus.gpios_tdo = 1'b0; g_cur = 1'b0;
    reset = 1'b1;
    @(posedge tck);
    model_step(1'b1, 1'b0, 1'b1);
    #1;
    check_outputs("reset");
    check("reset_tap_state_tlr", 32'(bus.tap_state), 32'(TAP_TLR));
    check("reset_tdo", 32'(bus.tdo), 32'd0);
    tick(0);

    // IDCODE read straight after reset
    rnd = {$urandom, $urandom};
    shift_dr(32, rnd, 64'd0, dout);
    check("idcode_stream", dout[31:0], IDV);
    check("idcode_first_bit", 32'(dout[0]), 32'd1);

    // IR capture pattern and SCAN_N decode
    load_ir(4'h2, seen);
    check("ir_capture_bits", 32'(seen), 32'h1);
    check("scan_n_sel", 32'(bus.scan_n_ir), 32'd1);
    check("scan_n_not_extest", 32'(bus.extest_ir), 32'd0);

    // BYPASS and an undefined opcode: one-cycle delay, leading 0
    load_ir(4'hF, seen);
    shift_dr(9, {55'd0, 1'b0, 8'hA5}, 64'd0, dout);
    check("bypass_f", dout[31:0], 32'h14A);
    load_ir(4'h7, seen);
    shift_dr(9, {55'd0, 1'b0, 8'hA5}, 64'd0, dout);
    check("bypass_7", dout[31:0], 32'h14A);

    // Opcode 3
    load_ir(4'h3, seen);
`ifdef JTAG_TAP_USERCODE_EN
    rnd = {$urandom, $urandom};
    shift_dr(32, rnd, 64'd0, dout);
    check("usercode_stream", dout[31:0], UCV);
`else
    shift_dr(9, {55'd0, 1'b0, 8'h3C}, 64'd0, dout);
    check("op3_bypass", dout[31:0], 32'h078);
`endif

    // EXTEST passthrough and single-cycle strobes
    load_ir(4'h0, seen);
    check("extest_sel", 32'(bus.extest_ir), 32'd1);
    cap_cnt = 0; upd_cnt = 0;
    rnd = {$urandom, $urandom};
    shift_dr(4, rnd, 64'b1101, dout);
    check("extest_tdo", dout[31:0], 32'b1101);
    check("capture_dr_once", 32'(cap_cnt), 32'd1);
    check("update_dr_once", 32'(upd_cnt), 32'd1);

    // Synchronous reset two bits into Shift-IR (IR currently EXTEST)
    tick(1); tick(1); tick(0); tick(0);
    tick(0, 1'b0); tick(0, 1'b1);
    tick(0, 1'b0, 1'b0, 1'b1);
    check("midreset_state", 32'(bus.tap_state), 32'(TAP_TLR));
    check("midreset_tdo_ena", 32'(bus.tdo_ena), 32'd0);
    check("midreset_extest", 32'(bus.extest_ir), 32'd0);
    check("midreset_scan_n", 32'(bus.scan_n_ir), 32'd0);
    tick(0);
    rnd = {$urandom, $urandom};
    shift_dr(32, rnd, 64'd0, dout);
    check("midreset_idcode", dout[31:0], IDV);

    // Five TMS=1 from every state
    for (int s = 0; s < 16; s++) begin
      load_ir(4'h0, seen);
      steps = 0;
      while (m_st != tap_state_e'(s) && steps < 300) begin
        tick(($urandom_range(0, 2) == 0), 1'($urandom));
        steps++;
      end
      if (m_st != tap_state_e'(s)) check("walk_reach", 32'(m_st), 32'(s));
      for (int k = 0; k < 5; k++) tick(1, 1'($urandom));
      check("tms5_state", 32'(bus.tap_state), 32'(TAP_TLR));
      tick(0);
      check("tms5_ir_idcode", 32'(bus.extest_ir | bus.scan_n_ir), 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 9) < 3), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 79) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
